// File: rtl/hyperram_port_pkg.sv
// -----------------------------------------------------------------------------
// hyperram_port_pkg
//
// Shared definitions for the HyperRAM byte port:
//   state_e         - adapter FSM states (IDLE / WAIT / RESP)
//   LANE_HI/LANE_LO - lane select: even byte address -> [15:8], odd -> [7:0]
//   DS_LANE_*       - active-high byte-enable patterns for each lane
//   AS_MEMORY       - controller address-space value for memory accesses
//   LINEAR_BURST    - controller burst-type value (linear)
//   lane_to_ds()    - lane select -> byte enables
//   lane_byte()     - pick the selected byte out of a 16-bit word
// -----------------------------------------------------------------------------
package hyperram_port_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic LANE_HI = 1'b0;
  localparam logic LANE_LO = 1'b1;

  localparam logic [1:0] DS_LANE_HI = 2'b10;
  localparam logic [1:0] DS_LANE_LO = 2'b01;

  localparam logic AS_MEMORY    = 1'b0;
  localparam logic LINEAR_BURST = 1'b1;

  function automatic logic [1:0] lane_to_ds(input logic lane);
    return (lane == LANE_LO) ? DS_LANE_LO : DS_LANE_HI;
  endfunction

  function automatic logic [7:0] lane_byte(input logic [15:0] word, input logic lane);
    return (lane == LANE_HI) ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/hyperram_rdbuf.sv
// -----------------------------------------------------------------------------
// hyperram_rdbuf
//
// One-word read buffer (tag, valid bit, 16-bit data) for the HyperRAM byte
// port. Only instantiated when HYPERRAM_BYTE_PORT_RDBUF_EN is defined.
//
// Ports:
//   clk, reset_b            clock, async active-low reset (clears valid)
//   inval                   clear the valid bit (wins over fill)
//   look_tag / hit / data   lookup: hit = valid && tag == look_tag
//   fill_en/fill_tag/fill_data  load a whole word and mark it valid
//   upd_en/upd_lane/upd_byte    write-through of one byte, applied only when
//                               the buffered word matches look_tag
// -----------------------------------------------------------------------------
module hyperram_rdbuf
  import hyperram_port_pkg::*;
#(
  parameter int TAG_BITS = 23
) (
  input  logic                clk,
  input  logic                reset_b,
  input  logic                inval,
  input  logic [TAG_BITS-1:0] look_tag,
  output logic                hit,
  output logic [15:0]         data,
  input  logic                fill_en,
  input  logic [TAG_BITS-1:0] fill_tag,
  input  logic [15:0]         fill_data,
  input  logic                upd_en,
  input  logic                upd_lane,
  input  logic [7:0]          upd_byte
);

  logic                valid;
  logic [TAG_BITS-1:0] tag;

  assign hit = valid && (tag == look_tag);

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      valid <= 1'b0;
    end else if (inval) begin
      valid <= 1'b0;
    end else if (fill_en) begin
      valid <= 1'b1;
    end
  end

  // NOTE: tag and data carry no reset; they are meaningless while valid=0,
  // and leaving them unreset keeps them plain enable flops.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag  <= fill_tag;
      data <= fill_data;
    end else if (upd_en && hit) begin
      if (upd_lane == LANE_HI) data[15:8] <= upd_byte;
      else                     data[7:0]  <= upd_byte;
    end
  end

endmodule

// File: rtl/hyperram_byte_port.sv
// -----------------------------------------------------------------------------
// hyperram_byte_port
//
// Byte-wide client adapter in front of the HyperRAM controller. Turns single
// byte read/write requests into 16-bit word transactions on the controller's
// toggle handshake (outstanding while req != ack).
//
// Optional feature: define HYPERRAM_BYTE_PORT_RDBUF_EN to add a one-word read
// buffer so repeated reads of the same word are served without a RAM access.
// Without it every read is a miss and inval is ignored.
//
// Ports:
//   clk, reset_b                 clock, async active-low reset
//   inval                        invalidate the read buffer
//   c_valid/c_ready/c_we         client request handshake and direction
//   c_addr, c_wdata              byte address and write byte
//   c_rdata, c_rvalid            read byte and its one-cycle strobe
//   as, linear_burst             constant controller attributes
//   we, a, d, ds                 controller command (held while outstanding)
//   q                            controller read data
//   req, ack                     request / completion toggles
// -----------------------------------------------------------------------------
module hyperram_byte_port
  import hyperram_port_pkg::*;
#(
  parameter int ADDR_BITS = 24
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic                 inval,
  input  logic                 c_valid,
  output logic                 c_ready,
  input  logic                 c_we,
  input  logic [ADDR_BITS-1:0] c_addr,
  input  logic [7:0]           c_wdata,
  output logic [7:0]           c_rdata,
  output logic                 c_rvalid,
  output logic                 as,
  output logic                 we,
  output logic                 linear_burst,
  output logic [31:0]          a,
  output logic [15:0]          d,
  output logic [1:0]           ds,
  input  logic [15:0]          q,
  output logic                 req,
  input  logic                 ack
);

  state_e state;
  logic   lane;      // lane of the outstanding access
  logic   is_read;   // outstanding access is a read
  logic   accept;
  logic   done;      // controller has caught up with our toggle
  logic   read_hit;  // buffered word matches and is usable this cycle
  logic [15:0] hit_data;

  assign as           = AS_MEMORY;
  assign linear_burst = LINEAR_BURST;
  assign c_ready      = (state == ST_IDLE);
  assign accept       = c_valid && c_ready;
  assign done         = (ack == req);

`ifdef HYPERRAM_BYTE_PORT_RDBUF_EN
  logic        buf_hit;
  logic        fill_en;
  logic        fill_block;

  // An inval seen while a read is in flight means the word about to arrive
  // may already be stale for whoever invalidated, so it must not be cached.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      fill_block <= 1'b0;
    end else if (accept) begin
      fill_block <= 1'b0;
    end else if (inval && (state != ST_IDLE)) begin
      fill_block <= 1'b1;
    end
  end

  assign fill_en  = (state == ST_WAIT) && done && is_read && !fill_block && !inval;
  assign read_hit = buf_hit && !inval;

  hyperram_rdbuf #(
    .TAG_BITS (ADDR_BITS - 1)
  ) u_rdbuf (
    .clk       (clk),
    .reset_b   (reset_b),
    .inval     (inval),
    .look_tag  (c_addr[ADDR_BITS-1:1]),
    .hit       (buf_hit),
    .data      (hit_data),
    .fill_en   (fill_en),
    .fill_tag  (a[ADDR_BITS-2:0]),
    .fill_data (q),
    .upd_en    (accept && c_we),
    .upd_lane  (c_addr[0]),
    .upd_byte  (c_wdata)
  );
`else
  logic unused_inval;

  assign unused_inval = inval;
  assign read_hit     = 1'b0;
  assign hit_data     = 16'h0000;
`endif

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state    <= ST_IDLE;
      req      <= 1'b0;
      c_rvalid <= 1'b0;
      c_rdata  <= 8'h00;
      we       <= 1'b0;
      a        <= 32'h0;
      d        <= 16'h0;
      ds       <= 2'b00;
      lane     <= LANE_HI;
      is_read  <= 1'b0;
    end else begin
      c_rvalid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (!c_we && read_hit) begin
              c_rdata  <= lane_byte(hit_data, c_addr[0]);
              c_rvalid <= 1'b1;
            end else begin
              // Bus command only moves together with the req toggle, so it
              // is stable for the whole time the transaction is outstanding.
              we      <= c_we;
              a       <= 32'(c_addr[ADDR_BITS-1:1]);
              d       <= {c_wdata, c_wdata};
              ds      <= lane_to_ds(c_addr[0]);
              lane    <= c_addr[0];
              is_read <= !c_we;
              req     <= ~req;
              state   <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (done) begin
            // Read data is captured on the edge that sees completion so the
            // strobe appears during the RESP cycle itself.
            if (is_read) begin
              c_rdata  <= lane_byte(q, lane);
              c_rvalid <= 1'b1;
            end
            state <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hyperram_byte_port.sv
// -----------------------------------------------------------------------------
// tb_hyperram_byte_port
//
// Directed bench for hyperram_byte_port with a behavioural controller model
// (word memory, programmable ack latency). Expectations adapt to whether
// HYPERRAM_BYTE_PORT_RDBUF_EN is defined.
// -----------------------------------------------------------------------------
module tb_hyperram_byte_port;

`ifdef HYPERRAM_BYTE_PORT_RDBUF_EN
  localparam bit RDBUF = 1'b1;
`else
  localparam bit RDBUF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        inval = 1'b0;
  logic        c_valid = 1'b0;
  logic        c_we = 1'b0;
  logic [23:0] c_addr = 24'h0;
  logic [7:0]  c_wdata = 8'h0;
  logic        c_ready;
  logic [7:0]  c_rdata;
  logic        c_rvalid;
  logic        as_sig;
  logic        we;
  logic        linear_burst;
  logic [31:0] a;
  logic [15:0] d;
  logic [1:0]  ds;
  logic [15:0] q = 16'h0;
  logic        req;
  logic        ack = 1'b0;

  hyperram_byte_port #(.ADDR_BITS(24)) dut (
    .clk          (clk),
    .reset_b      (reset_b),
    .inval        (inval),
    .c_valid      (c_valid),
    .c_ready      (c_ready),
    .c_we         (c_we),
    .c_addr       (c_addr),
    .c_wdata      (c_wdata),
    .c_rdata      (c_rdata),
    .c_rvalid     (c_rvalid),
    .as           (as_sig),
    .we           (we),
    .linear_burst (linear_burst),
    .a            (a),
    .d            (d),
    .ds           (ds),
    .q            (q),
    .req          (req),
    .ack          (ack)
  );

  always #5 clk = ~clk;

  // Controller model: completes an outstanding toggle after ctl_lat edges.
  logic [15:0] mem [int unsigned];
  int ctl_lat = 5;
  int ctl_cnt = 0;

  always @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      ack     <= 1'b0;
      ctl_cnt <= 0;
    end else if (req != ack) begin
      if (ctl_cnt + 1 >= ctl_lat) begin
        ack     <= req;
        ctl_cnt <= 0;
        if (we) begin
          logic [15:0] w;
          w = mem.exists(a) ? mem[a] : 16'h0;
          if (ds[1]) w[15:8] = d[15:8];
          if (ds[0]) w[7:0]  = d[7:0];
          mem[a] = w;
        end else begin
          q <= mem.exists(a) ? mem[a] : 16'h0;
        end
      end else begin
        ctl_cnt <= ctl_cnt + 1;
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // One client transaction, driven from a negedge with the port idle.
  // Returns when c_ready is seen again; inval pulses one cycle at inv_wait.
  task automatic do_txn(input logic wr, input logic [23:0] addr, input logic [7:0] wdata,
                        input logic inv, input int inv_wait,
                        output logic [7:0] rdata, output int toggles, output bit rv, output bit ok);
    logic last_req;
    rdata = 8'h0; toggles = 0; rv = 1'b0; ok = 1'b0;
    last_req = req;
    c_valid = 1'b1; c_we = wr; c_addr = addr; c_wdata = wdata; inval = inv;
    @(posedge clk);
    @(negedge clk);
    c_valid = 1'b0; c_we = 1'b0; inval = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (req !== last_req) begin toggles++; last_req = req; end
      if (c_rvalid === 1'b1) begin rdata = c_rdata; rv = 1'b1; end
      if (c_ready === 1'b1) begin ok = 1'b1; break; end
      inval = (inv_wait != 0 && n == inv_wait);
      @(negedge clk);
    end
    inval = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [23:0] addr;
    logic [7:0]  wdata;
    logic        inv;
    logic [7:0]  exp_rdata;
    bit          hit;
  } vec_t;

  vec_t vecs [15];

  initial begin
    logic [7:0] rdata;
    int toggles, exp_tog;
    bit rv, ok;
    int k_ack, k_rv, k_rdy;
    logic [7:0] first_rdata;
    logic [31:0] snap_a;
    logic [15:0] snap_d;
    logic [1:0]  snap_ds;
    logic        snap_we;
    int stall_bad;
    bit seen;

    mem[32'h80]     = 16'hA55A;
    mem[32'h101]    = 16'h1234;
    mem[32'h7FFFFF] = 16'hBEEF;

    vecs[0]  = '{1'b0, 24'h000100, 8'h00, 1'b0, 8'hA5, 1'b1};
    vecs[1]  = '{1'b1, 24'h000101, 8'h3C, 1'b0, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 24'h000101, 8'h00, 1'b0, 8'h3C, 1'b1};
    vecs[3]  = '{1'b0, 24'h000100, 8'h00, 1'b1, 8'hA5, 1'b0};
    vecs[4]  = '{1'b0, 24'h000100, 8'h00, 1'b0, 8'hA5, 1'b1};
    vecs[5]  = '{1'b0, 24'h000202, 8'h00, 1'b0, 8'h12, 1'b0};
    vecs[6]  = '{1'b0, 24'h000203, 8'h00, 1'b0, 8'h34, 1'b1};
    vecs[7]  = '{1'b1, 24'h000202, 8'hEE, 1'b0, 8'h00, 1'b0};
    vecs[8]  = '{1'b0, 24'h000202, 8'h00, 1'b0, 8'hEE, 1'b1};
    vecs[9]  = '{1'b1, 24'h000300, 8'h77, 1'b0, 8'h00, 1'b0};
    vecs[10] = '{1'b0, 24'h000203, 8'h00, 1'b0, 8'h34, 1'b1};
    vecs[11] = '{1'b0, 24'h000301, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[12] = '{1'b0, 24'h000300, 8'h00, 1'b0, 8'h77, 1'b1};
    vecs[13] = '{1'b0, 24'hFFFFFF, 8'h00, 1'b0, 8'hEF, 1'b0};
    vecs[14] = '{1'b0, 24'hFFFFFE, 8'h00, 1'b0, 8'hBE, 1'b1};

    // ---- reset state ----
    repeat (2) @(negedge clk);
    check("rst_req", 32'(req), 0);
    check("rst_ready", 32'(c_ready), 1);
    check("rst_rvalid", 32'(c_rvalid), 0);
    check("rst_rdata", 32'(c_rdata), 0);
    check("rst_we", 32'(we), 0);
    check("rst_a", a, 0);
    check("rst_d", 32'(d), 0);
    check("rst_ds", 32'(ds), 0);
    check("const_as", 32'(as_sig), 0);
    check("const_linear", 32'(linear_burst), 1);
    reset_b = 1'b1;
    @(negedge clk);

    // ---- first read 0x000101: cycle-accurate timing ----
    c_valid = 1'b1; c_we = 1'b0; c_addr = 24'h000101;
    @(posedge clk);
    @(negedge clk);
    c_valid = 1'b0;
    check("rd1_req", 32'(req), 1);
    check("rd1_ready", 32'(c_ready), 0);
    check("rd1_a", a, 32'h80);
    check("rd1_ds", 32'(ds), 32'h1);
    check("rd1_we", 32'(we), 0);
    k_ack = -1; k_rv = -1; k_rdy = -1; first_rdata = 8'h0;
    for (int k = 0; k < 100; k++) begin
      if (k_ack < 0 && ack === req) k_ack = k;
      if (k_rv < 0 && c_rvalid === 1'b1) begin k_rv = k; first_rdata = c_rdata; end
      if (c_ready === 1'b1) begin
        k_rdy = k;
        check("rd1_rvalid_pulse", 32'(c_rvalid), 0);
        break;
      end
      @(negedge clk);
    end
    check("rd1_done", 32'(k_rdy >= 0), 1);
    check("rd1_rdata", 32'(first_rdata), 32'h5A);
    check("rd1_rvalid_cycle", 32'(k_rv - k_ack), 1);
    check("rd1_ready_cycle", 32'(k_rdy - k_ack), 2);

    // ---- vector table ----
    for (int i = 0; i < 15; i++) begin
      do_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].inv, 0, rdata, toggles, rv, ok);
      exp_tog = (vecs[i].wr || !RDBUF || !vecs[i].hit) ? 1 : 0;
      check($sformatf("v%0d_done", i), 32'(ok), 1);
      check($sformatf("v%0d_toggles", i), 32'(toggles), 32'(exp_tog));
      check($sformatf("v%0d_rvalid", i), 32'(rv), 32'(!vecs[i].wr));
      check($sformatf("v%0d_rdata", i), 32'(rdata), 32'(vecs[i].exp_rdata));
      if (exp_tog == 1) begin
        check($sformatf("v%0d_a", i), a, {9'h0, vecs[i].addr[23:1]});
        check($sformatf("v%0d_ds", i), 32'(ds), vecs[i].addr[0] ? 32'h1 : 32'h2);
        check($sformatf("v%0d_d", i), 32'(d), {16'h0, vecs[i].wdata, vecs[i].wdata});
        check($sformatf("v%0d_we", i), 32'(we), 32'(vecs[i].wr));
      end
    end

    // ---- inval during WAIT, then immediate re-read of the same word ----
    do_txn(1'b0, 24'h000100, 8'h00, 1'b0, 1, rdata, toggles, rv, ok);
    check("invw_toggles", 32'(toggles), 1);
    check("invw_rdata", 32'(rdata), 32'hA5);
    do_txn(1'b0, 24'h000100, 8'h00, 1'b0, 0, rdata, toggles, rv, ok);
    check("invw_reread_toggles", 32'(toggles), 1);
    check("invw_reread_rdata", 32'(rdata), 32'hA5);
    do_txn(1'b0, 24'h000101, 8'h00, 1'b0, 0, rdata, toggles, rv, ok);
    check("invw_refill_toggles", 32'(toggles), RDBUF ? 32'd0 : 32'd1);
    check("invw_refill_rdata", 32'(rdata), 32'h3C);

    // ---- ack stalled for 50 cycles ----
    ctl_lat = 60;
    c_valid = 1'b1; c_we = 1'b1; c_addr = 24'h000401; c_wdata = 8'h99;
    @(posedge clk);
    @(negedge clk);
    c_valid = 1'b0; c_we = 1'b0;
    snap_a = a; snap_d = d; snap_ds = ds; snap_we = we;
    check("stall_a", a, 32'h200);
    check("stall_d", 32'(d), 32'h9999);
    check("stall_ds", 32'(ds), 32'h1);
    check("stall_we", 32'(we), 1);
    stall_bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (c_ready !== 1'b0 || a !== snap_a || d !== snap_d || ds !== snap_ds || we !== snap_we)
        stall_bad++;
    end
    check("stall_hold", 32'(stall_bad), 0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (c_ready === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check("stall_done", 32'(seen), 1);
    ctl_lat = 5;

    // ---- reset in mid-WAIT together with the controller ----
    ctl_lat = 20;
    c_valid = 1'b1; c_we = 1'b0; c_addr = 24'h000500;
    @(posedge clk);
    @(negedge clk);
    c_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_in_wait", 32'(c_ready), 0);
    reset_b = 1'b0;
    #1;
    check("mid_rst_req", 32'(req), 0);
    check("mid_rst_ack", 32'(ack), 0);
    check("mid_rst_ready", 32'(c_ready), 1);
    check("mid_rst_rvalid", 32'(c_rvalid), 0);
    check("mid_rst_rdata", 32'(c_rdata), 0);
    check("mid_rst_we", 32'(we), 0);
    check("mid_rst_a", a, 0);
    check("mid_rst_d", 32'(d), 0);
    check("mid_rst_ds", 32'(ds), 0);
    @(negedge clk);
    reset_b = 1'b1;
    ctl_lat = 5;
    @(negedge clk);
    do_txn(1'b0, 24'h000101, 8'h00, 1'b0, 0, rdata, toggles, rv, ok);
    check("post_rst_done", 32'(ok), 1);
    check("post_rst_toggles", 32'(toggles), 1);
    check("post_rst_rdata", 32'(rdata), 32'h3C);
    check("post_rst_a", a, 32'h80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so a stuck handshake can never hang the run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
